// File: rtl/xbar_cfg_loader_if.sv
// Bitstream word channel into the crossbar config loader.
interface xbar_cfg_loader_if #(parameter int DW = 8);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/xbar_cfg_loader.sv
// Crossbar config loader: assembles a bitstream frame in a shadow register,
// checks an XOR checksum word, then commits prog to the node arrays atomically.
module xbar_cfg_loader #(
  parameter int V  = 8,
  parameter int H  = 4,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  xbar_cfg_loader_if.slave    s,
  output logic [V*H-1:0]      prog,
  output logic                cfg_valid,
  output logic                busy,
  output logic                err
);
  localparam int PW = V*H;
  localparam int NW = (PW + DW - 1) / DW;
  localparam int CW = $clog2(NW) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, FAIL} state_t;

  state_t              r_state, w_nxt;
  logic [CW-1:0]       r_cnt;
  logic [DW-1:0]       r_chk;
  logic [NW*DW-1:0]    r_shadow;
  logic [PW-1:0]       r_prog;
  logic                r_cfg_valid, r_err;
  logic                w_rdy, w_busy, w_xfer, w_last;

  assign w_xfer      = s.din_valid & w_rdy;
  assign w_last      = (r_cnt == CW'(NW-1));
  assign s.din_ready = w_rdy;
  assign busy        = w_busy;
  assign prog        = r_prog;
  assign cfg_valid   = r_cfg_valid;
  assign err         = r_err;

  always_comb begin
    w_nxt  = r_state;
    w_rdy  = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      IDLE:   if (start) w_nxt = LOAD;
      LOAD: begin
        w_rdy  = 1'b1;
        w_busy = 1'b1;
        if (abort)                w_nxt = IDLE;
        else if (w_xfer && w_last) w_nxt = CHECK;
      end
      CHECK: begin
        w_rdy  = 1'b1;
        w_busy = 1'b1;
        if (abort)       w_nxt = IDLE;
        else if (w_xfer) w_nxt = (s.din == r_chk) ? COMMIT : FAIL;
      end
      COMMIT: begin
        w_busy = 1'b1;
        w_nxt  = IDLE;
      end
      FAIL: begin
        w_busy = 1'b1;
        w_nxt  = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_chk       <= '0;
      r_shadow    <= '0;
      r_prog      <= '0;
      r_cfg_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        IDLE: if (start) begin
          r_cnt       <= '0;
          r_chk       <= '0;
          r_shadow    <= '0;
          r_err       <= 1'b0;
          r_cfg_valid <= 1'b0;
        end
        // abort wins over a same-cycle transfer; the word is dropped
        LOAD: if (!abort && w_xfer) begin
          r_shadow[int'(r_cnt)*DW +: DW] <= s.din;
          r_chk <= r_chk ^ s.din;
          r_cnt <= r_cnt + 1'b1;
        end
        COMMIT: begin
          r_prog      <= r_shadow[PW-1:0];
          r_cfg_valid <= 1'b1;
        end
        FAIL:    r_err <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Directed bench for xbar_cfg_loader: good/bad frames, stalls, abort, reset mid-frame.
module tb_xbar_cfg_loader;
  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] prog;
  logic        cfg_valid, busy, err;
  int          n_cmp = 0, n_err = 0, n_xfer = 0;

  xbar_cfg_loader_if #(.DW(8)) bus ();

  xbar_cfg_loader #(.V(8), .H(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s(bus.slave),
    .prog(prog), .cfg_valid(cfg_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && bus.din_valid && bus.din_ready) n_xfer <= n_xfer + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // hold word until accepted; bounded wait
  task automatic send(input logic [7:0] w);
    bit done = 0;
    bus.din = w;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.din_ready) done = 1;
      tick();
    end
    if (!done) chk("send_timeout", 32'(w), 32'hDEAD_BEEF);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_prog", prog, 32'h0);
    chk("rst_cfgv", 32'(cfg_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rdy", 32'(bus.din_ready), 32'h0);

    // idle ignores din
    bus.din = 8'hFF; bus.din_valid = 1'b1;
    repeat (5) tick();
    chk("idle_prog", prog, 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_xfer", 32'(n_xfer), 32'd0);
    bus.din_valid = 1'b0;

    // good frame, back-to-back
    pulse_start();
    chk("load_busy", 32'(busy), 32'h1);
    chk("load_rdy", 32'(bus.din_ready), 32'h1);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0F);
    bus.din_valid = 1'b0;
    chk("commit_prog_old", prog, 32'h0);
    chk("commit_busy", 32'(busy), 32'h1);
    chk("commit_rdy", 32'(bus.din_ready), 32'h0);
    tick();
    chk("good_prog", prog, 32'h08040201);
    chk("good_cfgv", 32'(cfg_valid), 32'h1);
    chk("good_err", 32'(err), 32'h0);
    chk("good_busy", 32'(busy), 32'h0);

    // bad checksum
    pulse_start();
    chk("reload_cfgv", 32'(cfg_valid), 32'h0);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0E);
    bus.din_valid = 1'b0;
    chk("fail_err_pre", 32'(err), 32'h0);
    tick();
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_prog", prog, 32'h08040201);
    chk("bad_cfgv", 32'(cfg_valid), 32'h0);
    tick();
    chk("err_sticky", 32'(err), 32'h1);

    // stalls between words
    pulse_start();
    chk("start_clr_err", 32'(err), 32'h0);
    n_xfer = 0;
    send(8'h01);
    bus.din_valid = 1'b0; tick(); tick();
    send(8'h02);
    bus.din_valid = 1'b0; tick(); tick();
    send(8'h04);
    bus.din_valid = 1'b0; tick(); tick();
    send(8'h08);
    bus.din_valid = 1'b0; tick(); tick();
    chk("stall_hold_busy", 32'(busy), 32'h1);
    send(8'h0F);
    bus.din_valid = 1'b0;
    tick();
    chk("stall_prog", prog, 32'h08040201);
    chk("stall_cfgv", 32'(cfg_valid), 32'h1);
    chk("stall_xfer", 32'(n_xfer), 32'd5);

    // abort mid-frame, same-cycle word dropped
    pulse_start();
    send(8'hAA); send(8'h55);
    bus.din = 8'h33; bus.din_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; bus.din_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_prog", prog, 32'h08040201);
    chk("abort_err", 32'(err), 32'h0);
    chk("abort_cfgv", 32'(cfg_valid), 32'h0);

    // start during LOAD must not restart the frame
    pulse_start();
    send(8'h10);
    bus.din_valid = 1'b0;
    pulse_start();
    send(8'h20); send(8'h40); send(8'h80); send(8'hF0);
    bus.din_valid = 1'b0;
    tick();
    chk("restart_prog", prog, 32'h80402010);
    chk("restart_cfgv", 32'(cfg_valid), 32'h1);
    chk("restart_busy", 32'(busy), 32'h0);

    // reset while in CHECK
    pulse_start();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    bus.din_valid = 1'b0;
    chk("in_check_rdy", 32'(bus.din_ready), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_prog", prog, 32'h0);
    chk("mrst_cfgv", 32'(cfg_valid), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_rdy", 32'(bus.din_ready), 32'h0);
    chk("mrst_err", 32'(err), 32'h0);

    // all-ones frame
    pulse_start();
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF); send(8'h00);
    bus.din_valid = 1'b0;
    tick();
    chk("ones_prog", prog, 32'hFFFFFFFF);
    chk("ones_cfgv", 32'(cfg_valid), 32'h1);
    chk("ones_err", 32'(err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
